// File: rtl/wb_pkg.sv
// Shared Wishbone B4 definitions for the HyperRAM front end.
//
// Contents:
//   CTI_*        cycle type identifier encodings
//   BTE_LINEAR   linear burst type extension
//   arb_state_e  arbiter FSM states
//   cti_is_burst true for cycle types that promise a following beat
//   cti_ends     true for cycle types that close the cycle on their ack
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic logic cti_is_burst(input logic [2:0] cti);
    return (cti == CTI_CONST) || (cti == CTI_INCR);
  endfunction

  function automatic logic cti_ends(input logic [2:0] cti);
    return (cti == CTI_CLASSIC) || (cti == CTI_EOB);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//
// Ports:
//   req_i   N-bit request vector
//   last_i  index of the most recently served requester
//   grant_o one-hot grant of the first requester after last_i (wrapping),
//           all zero when nobody requests
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] last_i,
  output logic [N-1:0]  grant_o
);

  logic          found;
  logic [PW-1:0] idx;

  // Walk the ports starting just after the last winner; the last winner
  // itself is visited last so it only wins again if nobody else asks.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 1; i <= N; i++) begin
      idx = PW'((int'(last_i) + i) % N);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_hyper_arbiter.sv
// N-port Wishbone B4 registered-feedback arbiter in front of the wb_hyper
// data port. Round-robin, with bursts holding the grant until they end or
// until MAX_BEATS acks have been delivered.
//
// Ports:
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   m_*_i                packed master-side requests, port k at [k*W +: W]
//   m_dat_o, m_ack_o     read data (broadcast) and per-port acknowledge
//   s_*_o                slave-side request towards wb_hyper
//   s_dat_i, s_ack_i     slave response from wb_hyper
//   grant_o              one-hot current grant (zero while idle)
module wb_hyper_arbiter
  import wb_pkg::*;
#(
  parameter  int NUM_PORTS = 3,
  parameter  int AW        = 32,
  parameter  int DW        = 32,
  parameter  int MAX_BEATS = 16,
  localparam int SW        = DW / 8,
  localparam int PW        = $clog2(NUM_PORTS),
  localparam int BW        = $clog2(MAX_BEATS + 1)
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [NUM_PORTS*AW-1:0] m_adr_i,
  input  logic [NUM_PORTS*DW-1:0] m_dat_i,
  input  logic [NUM_PORTS*SW-1:0] m_sel_i,
  input  logic [NUM_PORTS-1:0]    m_we_i,
  input  logic [NUM_PORTS*3-1:0]  m_cti_i,
  input  logic [NUM_PORTS-1:0]    m_cyc_i,
  input  logic [NUM_PORTS-1:0]    m_stb_i,
  output logic [DW-1:0]           m_dat_o,
  output logic [NUM_PORTS-1:0]    m_ack_o,
  output logic [AW-1:0]           s_adr_o,
  output logic [DW-1:0]           s_dat_o,
  output logic [SW-1:0]           s_sel_o,
  output logic                    s_we_o,
  output logic [2:0]              s_cti_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  input  logic [DW-1:0]           s_dat_i,
  input  logic                    s_ack_i,
  output logic [NUM_PORTS-1:0]    grant_o
);

  arb_state_e             state_q, state_d;
  logic [NUM_PORTS-1:0]   grant_q, grant_d;
  logic [PW-1:0]          last_q, last_d;
  logic [BW-1:0]          beats_q, beats_d;

  logic [NUM_PORTS-1:0]   req;
  logic [NUM_PORTS-1:0]   rr_grant;
  logic [PW-1:0]          gidx;
  logic [PW-1:0]          sel_idx;
  logic                   in_grant;

  logic [AW-1:0]          adr_mux;
  logic [DW-1:0]          dat_mux;
  logic [SW-1:0]          sel_mux;
  logic                   we_mux;
  logic [2:0]             cti_mux;
  logic                   cyc_mux;
  logic                   stb_mux;
  logic                   force_eob;
  logic                   release_now;

  assign req      = m_cyc_i & m_stb_i;
  assign in_grant = (state_q == ST_GRANT);

  rr_arbiter #(.N(NUM_PORTS)) u_rr (
    .req_i   (req),
    .last_i  (last_q),
    .grant_o (rr_grant)
  );

  always_comb begin
    gidx = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (grant_q[k]) gidx = PW'(k);
    end
  end

  // While idle the mux keeps pointing at the last served port, so the
  // slave-side address/data stay on that port's values.
  assign sel_idx = in_grant ? gidx : last_q;

  always_comb begin
    adr_mux = '0;
    dat_mux = '0;
    sel_mux = '0;
    we_mux  = 1'b0;
    cti_mux = CTI_CLASSIC;
    cyc_mux = 1'b0;
    stb_mux = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (PW'(k) == sel_idx) begin
        adr_mux = m_adr_i[k*AW +: AW];
        dat_mux = m_dat_i[k*DW +: DW];
        sel_mux = m_sel_i[k*SW +: SW];
        we_mux  = m_we_i[k];
        cti_mux = m_cti_i[k*3 +: 3];
        cyc_mux = m_cyc_i[k];
        stb_mux = m_stb_i[k];
      end
    end
  end

  // On the last beat a long burst is allowed, pretend the master said
  // end-of-burst so wb_hyper closes its transfer cleanly; the master keeps
  // requesting and picks up again when it is re-granted.
  assign force_eob = in_grant && (beats_q == BW'(MAX_BEATS - 1)) && cti_is_burst(cti_mux);

  assign s_adr_o = adr_mux;
  assign s_dat_o = dat_mux;
  assign s_sel_o = sel_mux;
  assign s_we_o  = we_mux;
  assign s_cti_o = force_eob ? CTI_EOB : cti_mux;
  assign s_cyc_o = in_grant && cyc_mux;
  assign s_stb_o = in_grant && stb_mux;

  assign m_dat_o = s_dat_i;
  assign m_ack_o = grant_q & {NUM_PORTS{s_ack_i}};
  assign grant_o = grant_q;

  // A master dropping cyc ends its tenure at once, even before any ack.
  assign release_now = !cyc_mux || (s_ack_i && cti_ends(s_cti_o));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beats_d = beats_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          grant_d = rr_grant;
          beats_d = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (s_ack_i) beats_d = beats_q + BW'(1);
        if (release_now) begin
          grant_d = '0;
          last_d  = gidx;
          beats_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        beats_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pointer resets to the top port so the search starts at port 0.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= PW'(NUM_PORTS - 1);
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beats_q <= beats_d;
    end
  end

endmodule

// File: tb/tb_wb_hyper_arbiter.sv
// Directed bench for wb_hyper_arbiter: three behavioural masters, a small
// registered-feedback memory standing in for wb_hyper, and a monitor that
// logs grants, forced end-of-burst beats and bus-hygiene violations.
module tb_wb_hyper_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] mAdr [N];
  logic [31:0] mDat [N];
  logic [3:0]  mSel [N];
  logic [2:0]  mCti [N];
  logic        mWe  [N];
  logic        mCyc [N];
  logic        mStb [N];

  logic [N*AW-1:0] mAdrBus;
  logic [N*DW-1:0] mDatBus;
  logic [N*SW-1:0] mSelBus;
  logic [N*3-1:0]  mCtiBus;
  logic [N-1:0]    mWeBus, mCycBus, mStbBus;

  always_comb begin
    mAdrBus = '0; mDatBus = '0; mSelBus = '0; mCtiBus = '0;
    mWeBus = '0; mCycBus = '0; mStbBus = '0;
    for (int k = 0; k < N; k++) begin
      mAdrBus[k*AW +: AW] = mAdr[k];
      mDatBus[k*DW +: DW] = mDat[k];
      mSelBus[k*SW +: SW] = mSel[k];
      mCtiBus[k*3 +: 3]   = mCti[k];
      mWeBus[k]  = mWe[k];
      mCycBus[k] = mCyc[k];
      mStbBus[k] = mStb[k];
    end
  end

  logic [DW-1:0] mDatOut;
  logic [N-1:0]  mAckOut;
  logic [AW-1:0] sAdr;
  logic [DW-1:0] sDat;
  logic [SW-1:0] sSel;
  logic          sWe, sCyc, sStb;
  logic [2:0]    sCti;
  logic [DW-1:0] sDatIn;
  logic          sAck;
  logic [N-1:0]  grant;

  wb_hyper_arbiter #(.NUM_PORTS(N), .AW(AW), .DW(DW), .MAX_BEATS(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .m_adr_i  (mAdrBus),
    .m_dat_i  (mDatBus),
    .m_sel_i  (mSelBus),
    .m_we_i   (mWeBus),
    .m_cti_i  (mCtiBus),
    .m_cyc_i  (mCycBus),
    .m_stb_i  (mStbBus),
    .m_dat_o  (mDatOut),
    .m_ack_o  (mAckOut),
    .s_adr_o  (sAdr),
    .s_dat_o  (sDat),
    .s_sel_o  (sSel),
    .s_we_o   (sWe),
    .s_cti_o  (sCti),
    .s_cyc_o  (sCyc),
    .s_stb_o  (sStb),
    .s_dat_i  (sDatIn),
    .s_ack_i  (sAck),
    .grant_o  (grant)
  );

  // Memory slave: one ack per request, never two in a row, data registered.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (rst) begin
      sAck <= 1'b0;
    end else if (sCyc && sStb && !sAck) begin
      sAck   <= 1'b1;
      sDatIn <= mem[sAdr[9:2]];
      if (sWe) begin
        for (int b = 0; b < 4; b++)
          if (sSel[b]) mem[sAdr[9:2]][8*b +: 8] <= sDat[8*b +: 8];
      end
    end else begin
      sAck <= 1'b0;
    end
  end

  // Monitor: grant history, resume addresses, forced end-of-burst beats.
  logic [N-1:0] prevGrant = '0;
  int           backToBack = 0;
  int           badAck = 0;
  int           badCyc = 0;
  int           ackCnt [N];
  logic [N-1:0] grantLog [$];
  logic [31:0]  grantAdrLog [$];
  logic [31:0]  forcedAdr [$];

  always @(negedge clk) begin
    if (grant != prevGrant && grant != '0) begin
      grantLog.push_back(grant);
      grantAdrLog.push_back(sAdr);
      if (prevGrant != '0) backToBack++;
    end
    prevGrant = grant;
    if ((mAckOut & ~grant) != '0) badAck++;
    if (grant == '0 && (sCyc || sStb)) badCyc++;
    if (!$onehot0(grant)) badCyc++;
    for (int k = 0; k < N; k++) begin
      if (mAckOut[k]) ackCnt[k]++;
      if (sAck && sCyc && sCti == 3'b111 && grant[k] && mCti[k] != 3'b111)
        forcedAdr.push_back(sAdr);
    end
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] wdat  [N][64];
  logic [31:0] rdBuf [N][64];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] logAt(input int i);
    return (i < grantLog.size()) ? 32'(grantLog[i]) : 32'h0;
  endfunction

  // One master transaction: n beats from adr, classic or incrementing burst;
  // dropAfter > 0 aborts the cycle after that many acks.
  task automatic applyStimulus(input int p, input logic [31:0] adr, input int n,
                               input logic we, input logic burst, input int dropAfter);
    int beat;
    int waitCnt;
    logic [31:0] a;
    a = adr;
    beat = 0;
    @(posedge clk); #1;
    mCyc[p] = 1'b1; mStb[p] = 1'b1; mWe[p] = we; mSel[p] = 4'hf;
    mAdr[p] = a; mDat[p] = wdat[p][0];
    mCti[p] = !burst ? 3'b000 : ((n == 1) ? 3'b111 : 3'b010);
    while (beat < n) begin
      waitCnt = 0;
      @(negedge clk);
      while (!mAckOut[p] && waitCnt < 300) begin
        @(negedge clk);
        waitCnt++;
      end
      if (!mAckOut[p]) begin
        checkOutput($sformatf("p%0d_ack_timeout", p), 32'(beat), 32'(n));
        @(posedge clk); #1;
        mCyc[p] = 1'b0; mStb[p] = 1'b0; mCti[p] = 3'b000;
        return;
      end
      rdBuf[p][beat] = mDatOut;
      beat++;
      @(posedge clk); #1;
      if (beat == n || (dropAfter != 0 && beat == dropAfter)) begin
        mCyc[p] = 1'b0; mStb[p] = 1'b0; mCti[p] = 3'b000;
        return;
      end
      a = a + 32'd4;
      mAdr[p] = a;
      mDat[p] = wdat[p][beat];
      if (burst && beat == n - 1) mCti[p] = 3'b111;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin
    int got;
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      mAdr[k] = '0; mDat[k] = '0; mSel[k] = '0; mCti[k] = '0;
      mWe[k] = 1'b0; mCyc[k] = 1'b0; mStb[k] = 1'b0; ackCnt[k] = 0;
      for (int i = 0; i < 64; i++) begin
        wdat[k][i] = '0;
        rdBuf[k][i] = '0;
      end
    end
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    for (int i = 0; i < 32; i++) wdat[0][i] = 32'hA500_0000 | 32'(i);
    wdat[1][0] = 32'h0102_0304; wdat[1][1] = 32'h0506_0708;
    wdat[1][2] = 32'h090a_0b0c; wdat[1][3] = 32'h0d0e_0f00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_grant", 32'(grant), 32'h0);
    checkOutput("reset_cyc", 32'(sCyc), 32'h0);
    checkOutput("reset_ack", 32'(mAckOut), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] three simultaneous classic reads");
    grantLog.delete();
    fork
      applyStimulus(0, 32'h10, 1, 1'b0, 1'b0, 0);
      applyStimulus(1, 32'h20, 1, 1'b0, 1'b0, 0);
      applyStimulus(2, 32'h30, 1, 1'b0, 1'b0, 0);
    join
    checkOutput("rr_count", 32'(grantLog.size()), 32'd3);
    checkOutput("rr_first", logAt(0), 32'h1);
    checkOutput("rr_second", logAt(1), 32'h2);
    checkOutput("rr_third", logAt(2), 32'h4);
    checkOutput("rr_data0", rdBuf[0][0], 32'hC0DE_0004);
    checkOutput("rr_data1", rdBuf[1][0], 32'hC0DE_0008);
    checkOutput("rr_data2", rdBuf[2][0], 32'hC0DE_000C);

    $display("[TB] single classic write then read on port 0");
    @(posedge clk); #1;
    mCyc[0] = 1'b1; mStb[0] = 1'b1; mWe[0] = 1'b1; mSel[0] = 4'hf;
    mAdr[0] = 32'h0; mDat[0] = 32'h1234_5678; mCti[0] = 3'b000;
    @(negedge clk);
    checkOutput("w_arb_latency_cyc", 32'(sCyc), 32'h0);
    @(negedge clk);
    checkOutput("w_cyc_rise", 32'(sCyc), 32'h1);
    checkOutput("w_grant", 32'(grant), 32'h1);
    checkOutput("w_adr", sAdr, 32'h0);
    checkOutput("w_dat", sDat, 32'h1234_5678);
    @(negedge clk);
    checkOutput("w_ack", 32'(mAckOut), 32'h1);
    @(posedge clk); #1;
    mCyc[0] = 1'b0; mStb[0] = 1'b0; mWe[0] = 1'b0;
    @(negedge clk);
    checkOutput("w_grant_drop", 32'(grant), 32'h0);
    checkOutput("w_cyc_drop", 32'(sCyc), 32'h0);
    applyStimulus(0, 32'h0, 1, 1'b0, 1'b0, 0);
    checkOutput("w_readback", rdBuf[0][0], 32'h1234_5678);

    $display("[TB] 4-beat burst on port 1 with port 2 waiting");
    grantLog.delete();
    fork
      applyStimulus(1, 32'h200, 4, 1'b1, 1'b1, 0);
      begin
        repeat (2) @(posedge clk);
        applyStimulus(2, 32'h30, 1, 1'b0, 1'b0, 0);
      end
    join
    checkOutput("b4_grants", 32'(grantLog.size()), 32'd2);
    checkOutput("b4_first", logAt(0), 32'h2);
    checkOutput("b4_second", logAt(1), 32'h4);
    checkOutput("b4_p2_data", rdBuf[2][0], 32'hC0DE_000C);
    applyStimulus(1, 32'h200, 4, 1'b0, 1'b1, 0);
    checkOutput("b4_rd0", rdBuf[1][0], 32'h0102_0304);
    checkOutput("b4_rd1", rdBuf[1][1], 32'h0506_0708);
    checkOutput("b4_rd2", rdBuf[1][2], 32'h090a_0b0c);
    checkOutput("b4_rd3", rdBuf[1][3], 32'h0d0e_0f00);

    $display("[TB] 32-beat burst on port 0 split by the beat cap");
    grantLog.delete(); grantAdrLog.delete(); forcedAdr.delete();
    fork
      applyStimulus(0, 32'h100, 32, 1'b1, 1'b1, 0);
      begin
        repeat (3) @(posedge clk);
        applyStimulus(1, 32'h10, 1, 1'b0, 1'b0, 0);
      end
    join
    checkOutput("cap_grants", 32'(grantLog.size()), 32'd3);
    checkOutput("cap_first", logAt(0), 32'h1);
    checkOutput("cap_second", logAt(1), 32'h2);
    checkOutput("cap_third", logAt(2), 32'h1);
    checkOutput("cap_resume_adr", (grantAdrLog.size() > 2) ? grantAdrLog[2] : 32'h0, 32'h140);
    checkOutput("cap_forced_count", 32'(forcedAdr.size()), 32'd1);
    checkOutput("cap_forced_adr", (forcedAdr.size() > 0) ? forcedAdr[0] : 32'h0, 32'h13C);
    checkOutput("cap_p1_data", rdBuf[1][0], 32'hC0DE_0004);
    applyStimulus(0, 32'h100, 32, 1'b0, 1'b1, 0);
    for (int i = 0; i < 32; i++)
      checkOutput($sformatf("cap_rd%0d", i), rdBuf[0][i], 32'hA500_0000 | 32'(i));

    $display("[TB] port 0 aborts burst after two acks");
    fork
      begin
        applyStimulus(0, 32'h100, 4, 1'b0, 1'b1, 2);
        @(negedge clk);
        checkOutput("abort_cyc_fall", 32'(sCyc), 32'h0);
        checkOutput("abort_still_granted", 32'(grant), 32'h1);
        @(negedge clk);
        checkOutput("abort_idle", 32'(grant), 32'h0);
        @(negedge clk);
        checkOutput("abort_next_grant", 32'(grant), 32'h2);
      end
      begin
        repeat (2) @(posedge clk);
        applyStimulus(1, 32'h200, 1, 1'b0, 1'b0, 0);
      end
    join
    checkOutput("abort_p1_data", rdBuf[1][0], 32'h0102_0304);

    $display("[TB] reset pulse during port 2 burst");
    ackCnt[2] = 0;
    fork
      applyStimulus(2, 32'h300, 8, 1'b0, 1'b1, 0);
      begin
        for (int i = 0; i < 200 && ackCnt[2] < 3; i++) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        mCyc[0] = 1'b1; mStb[0] = 1'b1; mWe[0] = 1'b0; mSel[0] = 4'hf;
        mAdr[0] = 32'h20; mCti[0] = 3'b000;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_grant", 32'(grant), 32'h0);
        checkOutput("rst_cyc", 32'(sCyc), 32'h0);
        @(negedge clk);
        checkOutput("rst_port0_first", 32'(grant), 32'h1);
        got = 0;
        for (int i = 0; i < 50; i++) begin
          if (mAckOut[0]) begin
            got = 1;
            break;
          end
          @(negedge clk);
        end
        checkOutput("rst_p0_ack", 32'(got), 32'h1);
        checkOutput("rst_p0_data", mDatOut, 32'hC0DE_0008);
        @(posedge clk); #1;
        mCyc[0] = 1'b0; mStb[0] = 1'b0;
      end
    join
    checkOutput("rst_p2_beats", 32'(ackCnt[2]), 32'd8);
    checkOutput("rst_p2_last", rdBuf[2][7], 32'hC0DE_00C7);

    checkOutput("no_ack_ungranted", 32'(badAck), 32'h0);
    checkOutput("no_cyc_idle", 32'(badCyc), 32'h0);
    checkOutput("idle_between_grants", 32'(backToBack), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_hyper_arbiter.md
Name: wb_hyper_arbiter

Overview:
- Parametrised N-port Wishbone B4 registered-feedback arbiter that sits in front of the wb_hyper data port. It lets several bus masters share one HyperRAM: video capture DMA, SD writer and CPU.
- Round-robin arbitration; a burst keeps the grant until it ends, or until a fairness cap forces it off. The cfg port of wb_hyper is not routed through this block.

Parameters:
- NUM_PORTS, 3, number of master ports (2..8)
- AW, 32, address width
- DW, 32, data width (SW = DW/8 select bits)
- MAX_BEATS, 16, maximum acks per grant before the burst is forcibly terminated (1..256)

Ports:
- wb_clk_i  in  1  system clock; all logic on its rising edge
- wb_rst_i  in  1  synchronous, active-high reset
- m_adr_i  in  NUM_PORTS*AW  master addresses, port k at [k*AW +: AW]
- m_dat_i  in  NUM_PORTS*DW  master write data
- m_sel_i  in  NUM_PORTS*SW  master byte selects
- m_we_i  in  NUM_PORTS  write enables
- m_cti_i  in  NUM_PORTS*3  cycle type identifiers
- m_cyc_i  in  NUM_PORTS  cycle valid
- m_stb_i  in  NUM_PORTS  strobe
- m_dat_o  out  DW  read data, broadcast to all ports
- m_ack_o  out  NUM_PORTS  per-port acknowledge
- s_adr_o  out  AW  to wb_hyper wb_adr_i
- s_dat_o  out  DW  to wb_hyper wb_dat_i
- s_sel_o  out  SW  to wb_hyper wb_sel_i
- s_we_o  out  1  to wb_hyper wb_we_i
- s_cti_o  out  3  to wb_hyper wb_cti_i
- s_cyc_o  out  1  to wb_hyper wb_cyc_i
- s_stb_o  out  1  to wb_hyper wb_stb_i
- s_dat_i  in  DW  from wb_hyper wb_dat_o
- s_ack_i  in  1  from wb_hyper wb_ack_o
- grant_o  out  NUM_PORTS  one-hot current grant, for debug and performance counters

Behaviour:
- Reset (synchronous, wb_rst_i high at a clock edge):
  - state=IDLE, grant_o=0, beat counter=0.
  - Last-grant pointer = NUM_PORTS-1, so port 0 wins first.
  - s_cyc_o=0, s_stb_o=0, m_ack_o=0 from the next edge.
  - Reset asserted mid-burst abandons the burst immediately; wb_hyper sees cyc fall.
- Request: req[k] = m_cyc_i[k] & m_stb_i[k].
- IDLE:
  - If any req, register the one-hot grant of the first requester searching from last_grant+1 upward, with wrap-around. Go to GRANT.
  - No slave cycle is issued in IDLE, so there is 1 cycle of arbitration latency.
- GRANT:
  - s_* outputs are a combinational mux of the granted port's signals.
  - s_cyc_o/s_stb_o follow that port's cyc/stb.
  - m_ack_o[g] = s_ack_i; all other acks are 0. m_dat_o = s_dat_i unconditionally.
  - The beat counter increments on each s_ack_i.
- Release conditions (go to IDLE next cycle, last_grant=g, counter=0):
  - m_cyc_i[g] falls (master abort or normal end), checked every cycle, including before the first ack;
  - or s_ack_i while s_cti_o is 3'b000 (classic) or 3'b111 (end of burst).
- Fairness cap:
  - When the beat counter = MAX_BEATS-1 and the master's cti is 3'b001 or 3'b010, force s_cti_o=3'b111 for that beat. wb_hyper then closes its burst.
  - On that ack, release as above.
  - The master keeps cyc/stb asserted with the next address; it re-arbitrates and resumes from its current m_adr_i when granted again.
  - MAX_BEATS=1 degrades every access to single beats.
- Simultaneous events:
  - Release and new requests in the same cycle: IDLE is always visited for 1 cycle; no back-to-back grant.
  - A port whose cyc drops while it is not granted is ignored; there is no queued state.
- Bus hygiene:
  - Ungranted ports never see ack.
  - s_cyc_o is 0 in IDLE even if requests are present.
  - s_adr_o, s_dat_o and s_sel_o hold the last granted port's values in IDLE (don't-care to the slave).
- Width rules: beat counter is $clog2(MAX_BEATS+1) bits; the pointer is $clog2(NUM_PORTS) bits and wraps at NUM_PORTS-1 to 0.

Decomposition:
- Package wb_pkg: CTI_CLASSIC=3'b000, CTI_CONST=3'b001, CTI_INCR=3'b010, CTI_EOB=3'b111; BTE_LINEAR constant.
- Sub-module rr_arbiter (parameter N): combinational round-robin picker. Inputs: req, last pointer. Output: one-hot grant. Reusable elsewhere.
- Top module: FSM, beat counter, muxing.

Test Plan:
- Single port 0 classic write of 0x12345678 to 0x0000_0000, then read:
  - s_cyc_o rises 1 cycle after req; m_ack_o=3'b001; read returns 0x12345678; grant drops 1 cycle after ack.
- Ports 0, 1 and 2 each request one classic read in the same cycle:
  - grant order 0, 1, 2; one IDLE cycle between grants; no ack on ungranted ports.
- Port 1 incrementing burst of 4 beats (0x01020304, 0x05060708, 0x090a0b0c, 0x0d0e0f00) with port 2 requesting:
  - port 2 waits until the 4th ack (cti 3'b111); burst read-back matches.
- MAX_BEATS=16, port 0 32-beat incrementing burst from 0x100 with port 1 requesting:
  - s_cti_o=3'b111 on beat 16; port 1 is served; port 0 resumes at 0x140; all 32 words are correct.
- Port 0 drops cyc after 2 of 4 burst acks:
  - IDLE next cycle; port 1 is granted 1 cycle later; wb_hyper sees cyc fall.
- wb_rst_i pulsed high for 1 cycle mid-burst on port 2:
  - grant_o=0 and s_cyc_o=0 next cycle; the next arbitration picks port 0 first.
